// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions: opcodes, functs, ALU encodings and the
// instruction decode helper used by the ID stage.
package mips_defs_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [4:0]  NOPRegAddr = 5'd0;
    localparam logic [31:0] ZeroWord   = 32'h0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'h00;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'h02;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'h03;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'h21;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP = 8'h23;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'h24;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'h26;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'h27;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'h7C;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP   = 8'hE3;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP       = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC     = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT     = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH     = 3'b100;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOADSTORE = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_ZEXT,
        IMM_SEXT,
        IMM_LUI,
        IMM_SHAMT
    } imm_kind_e;

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic                rd1;
        logic                rd2;
        logic                wreg;
        logic                wd_rt;
        logic                is_load;
        logic                invalid;
        imm_kind_e           imm_kind;
    } dec_t;

    function automatic dec_t decode_inst(input logic [31:0] inst);
        dec_t d;
        d          = '0;
        d.aluop    = EXE_NOP_OP;
        d.alusel   = EXE_RES_NOP;
        d.imm_kind = IMM_NONE;
        d.invalid  = 1'b1;
        case (inst[31:26])
            OP_SPECIAL: begin
                d.invalid = 1'b0;
                d.wreg    = 1'b1;
                d.rd1     = 1'b1;
                d.rd2     = 1'b1;
                case (inst[5:0])
                    FN_AND:  begin d.aluop = EXE_AND_OP;  d.alusel = EXE_RES_LOGIC; end
                    FN_OR:   begin d.aluop = EXE_OR_OP;   d.alusel = EXE_RES_LOGIC; end
                    FN_XOR:  begin d.aluop = EXE_XOR_OP;  d.alusel = EXE_RES_LOGIC; end
                    FN_NOR:  begin d.aluop = EXE_NOR_OP;  d.alusel = EXE_RES_LOGIC; end
                    FN_ADDU: begin d.aluop = EXE_ADDU_OP; d.alusel = EXE_RES_ARITH; end
                    FN_SUBU: begin d.aluop = EXE_SUBU_OP; d.alusel = EXE_RES_ARITH; end
                    FN_SLT:  begin d.aluop = EXE_SLT_OP;  d.alusel = EXE_RES_ARITH; end
                    // shifts take the shift amount on port 1 instead of rs
                    FN_SLL:  begin d.aluop = EXE_SLL_OP; d.alusel = EXE_RES_SHIFT; d.rd1 = 1'b0; d.imm_kind = IMM_SHAMT; end
                    FN_SRL:  begin d.aluop = EXE_SRL_OP; d.alusel = EXE_RES_SHIFT; d.rd1 = 1'b0; d.imm_kind = IMM_SHAMT; end
                    FN_SRA:  begin d.aluop = EXE_SRA_OP; d.alusel = EXE_RES_SHIFT; d.rd1 = 1'b0; d.imm_kind = IMM_SHAMT; end
                    default: begin
                        d.invalid = 1'b1;
                        d.wreg    = 1'b0;
                        d.rd1     = 1'b0;
                        d.rd2     = 1'b0;
                    end
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                d.invalid  = 1'b0;
                d.wreg     = 1'b1;
                d.wd_rt    = 1'b1;
                d.rd1      = 1'b1;
                d.imm_kind = IMM_ZEXT;
                d.alusel   = EXE_RES_LOGIC;
                d.aluop    = (inst[31:26] == OP_ORI)  ? EXE_OR_OP  :
                             (inst[31:26] == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
            end
            OP_LUI: begin
                d.invalid  = 1'b0;
                d.wreg     = 1'b1;
                d.wd_rt    = 1'b1;
                d.imm_kind = IMM_LUI;
                d.aluop    = EXE_OR_OP;
                d.alusel   = EXE_RES_LOGIC;
            end
            OP_LW: begin
                d.invalid  = 1'b0;
                d.wreg     = 1'b1;
                d.wd_rt    = 1'b1;
                d.rd1      = 1'b1;
                d.is_load  = 1'b1;
                d.imm_kind = IMM_SEXT;
                d.aluop    = EXE_LW_OP;
                d.alusel   = EXE_RES_LOADSTORE;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Single-operand source select: immediate, register 0, EX/MEM forward or
// register file. Also reports raw EX/MEM address hits for hazard logic.
module id_fwd_mux
    import mips_defs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              rd,
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] data,
    output logic              ex_hit,
    output logic              mem_hit
);

    logic addr_nz;

    assign addr_nz = (addr != '0);
    assign ex_hit  = rd && addr_nz && ex_wreg  && (ex_wd  == addr);
    assign mem_hit = rd && addr_nz && mem_wreg && (mem_wd == addr);

    // EX is younger than MEM, so its value wins when both match
    always_comb begin
        data = rf_data;
        if (!rd)
            data = imm;
        else if (!addr_nz)
            data = '0;
        else if (FWD_EN && ex_hit)
            data = ex_wdata;
        else if (FWD_EN && mem_hit)
            data = mem_wdata;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage with forwarding, load-use bubble insertion and the
// ID/EX pipeline register.
module id_stage_pipe
    import mips_defs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         inst_i,
    input  logic                in_valid_i,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic [REG_AW-1:0]   ex_wd_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                ex_is_load_i,
    input  logic                mem_wreg_i,
    input  logic [REG_AW-1:0]   mem_wd_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [REG_AW-1:0]   reg1_addr_o,
    output logic [REG_AW-1:0]   reg2_addr_o,
    output logic                stall_req_o,
    output logic                ex_valid_o,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic [ALUSEL_W-1:0] ex_alusel_o,
    output logic [DATA_W-1:0]   ex_reg1_o,
    output logic [DATA_W-1:0]   ex_reg2_o,
    output logic [REG_AW-1:0]   ex_wd_o,
    output logic                ex_wreg_o,
    output logic [31:0]         ex_pc_o,
    output logic                ex_is_load_o,
    output logic                ex_invalid_o
);

    dec_t              dec;
    logic              run;
    logic [31:0]       imm32;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hit1_ex, hit1_mem, hit2_ex, hit2_mem;
    logic              load_use;
    logic              raw_stall;
    logic [REG_AW-1:0] wd_next;
    logic              bubble;

    assign dec = decode_inst(inst_i);
    assign run = (rst != RstEnable);

    always_comb begin
        imm32 = ZeroWord;
        case (dec.imm_kind)
            IMM_ZEXT:  imm32 = {16'h0, inst_i[15:0]};
            IMM_SEXT:  imm32 = {{16{inst_i[15]}}, inst_i[15:0]};
            IMM_LUI:   imm32 = {inst_i[15:0], 16'h0};
            IMM_SHAMT: imm32 = {27'h0, inst_i[10:6]};
            default:   imm32 = ZeroWord;
        endcase
    end

    assign imm = DATA_W'(imm32);

    assign reg1_read_o = run && dec.rd1;
    assign reg2_read_o = run && dec.rd2;
    assign reg1_addr_o = run ? REG_AW'(inst_i[25:21]) : '0;
    assign reg2_addr_o = run ? REG_AW'(inst_i[20:16]) : '0;

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
        .rd        (reg1_read_o),
        .addr      (reg1_addr_o),
        .rf_data   (reg1_data_i),
        .imm       (imm),
        .ex_wreg   (ex_wreg_i),
        .ex_wd     (ex_wd_i),
        .ex_wdata  (ex_wdata_i),
        .mem_wreg  (mem_wreg_i),
        .mem_wd    (mem_wd_i),
        .mem_wdata (mem_wdata_i),
        .data      (op1),
        .ex_hit    (hit1_ex),
        .mem_hit   (hit1_mem)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
        .rd        (reg2_read_o),
        .addr      (reg2_addr_o),
        .rf_data   (reg2_data_i),
        .imm       (imm),
        .ex_wreg   (ex_wreg_i),
        .ex_wd     (ex_wd_i),
        .ex_wdata  (ex_wdata_i),
        .mem_wreg  (mem_wreg_i),
        .mem_wd    (mem_wd_i),
        .mem_wdata (mem_wdata_i),
        .data      (op2),
        .ex_hit    (hit2_ex),
        .mem_hit   (hit2_mem)
    );

    // Without forwarding every in-flight producer match has to wait it out
    assign load_use    = ex_is_load_i && (hit1_ex || hit2_ex);
    assign raw_stall   = !FWD_EN && (hit1_ex || hit2_ex || hit1_mem || hit2_mem);
    assign stall_req_o = run && in_valid_i && (load_use || raw_stall);

    assign wd_next = dec.wd_rt ? REG_AW'(inst_i[20:16]) : REG_AW'(inst_i[15:11]);
    assign bubble  = flush_i || (!stall_i && stall_req_o);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || bubble) begin
            ex_valid_o   <= 1'b0;
            ex_aluop_o   <= EXE_NOP_OP;
            ex_alusel_o  <= EXE_RES_NOP;
            ex_reg1_o    <= '0;
            ex_reg2_o    <= '0;
            ex_wd_o      <= REG_AW'(NOPRegAddr);
            ex_wreg_o    <= 1'b0;
            ex_pc_o      <= ZeroWord;
            ex_is_load_o <= 1'b0;
            ex_invalid_o <= 1'b0;
        end else if (!stall_i) begin
            ex_valid_o   <= in_valid_i;
            ex_aluop_o   <= dec.aluop;
            ex_alusel_o  <= dec.alusel;
            ex_reg1_o    <= op1;
            ex_reg2_o    <= op2;
            ex_wd_o      <= wd_next;
            ex_wreg_o    <= dec.wreg && in_valid_i;
            ex_pc_o      <= pc_i;
            ex_is_load_o <= dec.is_load && in_valid_i;
            ex_invalid_o <= dec.invalid && in_valid_i;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one forwarding instance and one
// stall-only instance share the same stimulus.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, inst_i;
    logic        in_valid_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stall_i, flush_i;

    logic        reg1_read_o, reg2_read_o, stall_req_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wd_o;
    logic        ex_valid_o, ex_wreg_o, ex_is_load_o, ex_invalid_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [31:0] ex_reg1_o, ex_reg2_o, ex_pc_o;

    logic        nf_reg1_read, nf_reg2_read, nf_stall_req;
    logic [4:0]  nf_reg1_addr, nf_reg2_addr, nf_wd;
    logic        nf_valid, nf_wreg, nf_is_load, nf_invalid;
    logic [7:0]  nf_aluop;
    logic [2:0]  nf_alusel;
    logic [31:0] nf_reg1, nf_reg2, nf_pc;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .REG_AW(5), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .in_valid_i(in_valid_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .stall_req_o(stall_req_o),
        .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_pc_o(ex_pc_o), .ex_is_load_o(ex_is_load_o), .ex_invalid_o(ex_invalid_o)
    );

    id_stage_pipe #(.DATA_W(32), .REG_AW(5), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .in_valid_i(in_valid_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .reg1_read_o(nf_reg1_read), .reg2_read_o(nf_reg2_read),
        .reg1_addr_o(nf_reg1_addr), .reg2_addr_o(nf_reg2_addr), .stall_req_o(nf_stall_req),
        .ex_valid_o(nf_valid), .ex_aluop_o(nf_aluop), .ex_alusel_o(nf_alusel),
        .ex_reg1_o(nf_reg1), .ex_reg2_o(nf_reg2), .ex_wd_o(nf_wd), .ex_wreg_o(nf_wreg),
        .ex_pc_o(nf_pc), .ex_is_load_o(nf_is_load), .ex_invalid_o(nf_invalid)
    );

    task automatic idle_inputs();
        pc_i = 32'h0; inst_i = 32'h0; in_valid_i = 1'b0;
        reg1_data_i = 32'h0; reg2_data_i = 32'h0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        inst_i = 32'h0022_1821; in_valid_i = 1'b1;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_is_load_i = 1'b1;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b0) begin err_cnt++; $display("FAIL rst_stall_req: got %b exp 0", stall_req_o); end
        vec_cnt++; if (reg1_read_o !== 1'b0 || reg1_addr_o !== 5'd0) begin err_cnt++; $display("FAIL rst_read1: got %b/%0d exp 0/0", reg1_read_o, reg1_addr_o); end
        @(posedge clk); #1;
        vec_cnt++; if ({ex_valid_o, ex_wreg_o, ex_is_load_o, ex_invalid_o} !== 4'b0) begin err_cnt++; $display("FAIL rst_flags: got %b exp 0000", {ex_valid_o, ex_wreg_o, ex_is_load_o, ex_invalid_o}); end
        vec_cnt++; if (ex_aluop_o !== 8'h00 || ex_alusel_o !== 3'b000) begin err_cnt++; $display("FAIL rst_alu: got %h/%b exp 00/000", ex_aluop_o, ex_alusel_o); end
        vec_cnt++; if (ex_reg1_o !== 32'h0 || ex_reg2_o !== 32'h0 || ex_pc_o !== 32'h0 || ex_wd_o !== 5'd0) begin err_cnt++; $display("FAIL rst_data: got %h %h %h %0d exp zeros", ex_reg1_o, ex_reg2_o, ex_pc_o, ex_wd_o); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_ori();
        @(negedge clk);
        idle_inputs();
        pc_i = 32'h0000_0100; inst_i = 32'h3422_00FF; in_valid_i = 1'b1;
        reg1_data_i = 32'h1234_0000;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b0) begin err_cnt++; $display("FAIL ori_stall: got %b exp 0", stall_req_o); end
        vec_cnt++; if (reg1_read_o !== 1'b1 || reg2_read_o !== 1'b0 || reg1_addr_o !== 5'd1) begin err_cnt++; $display("FAIL ori_read: got %b%b %0d exp 10 1", reg1_read_o, reg2_read_o, reg1_addr_o); end
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'h1234_0000) begin err_cnt++; $display("FAIL ori_reg1: got %h exp 12340000", ex_reg1_o); end
        vec_cnt++; if (ex_reg2_o !== 32'h0000_00FF) begin err_cnt++; $display("FAIL ori_reg2: got %h exp 000000ff", ex_reg2_o); end
        vec_cnt++; if (ex_wd_o !== 5'd2 || ex_wreg_o !== 1'b1 || ex_valid_o !== 1'b1) begin err_cnt++; $display("FAIL ori_wd: got %0d %b %b exp 2 1 1", ex_wd_o, ex_wreg_o, ex_valid_o); end
        vec_cnt++; if (ex_aluop_o !== 8'h25 || ex_alusel_o !== 3'b001 || ex_pc_o !== 32'h100) begin err_cnt++; $display("FAIL ori_op: got %h %b %h exp 25 001 100", ex_aluop_o, ex_alusel_o, ex_pc_o); end
    endtask

    task automatic test_imm_forms();
        // LUI $8,0x1234 : both ports take {imm,16'h0}
        @(negedge clk);
        idle_inputs();
        inst_i = 32'h3C08_1234; in_valid_i = 1'b1; reg1_data_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'h1234_0000 || ex_reg2_o !== 32'h1234_0000) begin err_cnt++; $display("FAIL lui_ops: got %h %h exp 12340000 12340000", ex_reg1_o, ex_reg2_o); end
        vec_cnt++; if (ex_wd_o !== 5'd8 || ex_aluop_o !== 8'h25) begin err_cnt++; $display("FAIL lui_wd: got %0d %h exp 8 25", ex_wd_o, ex_aluop_o); end
        // SRA $9,$10,4
        @(negedge clk);
        idle_inputs();
        inst_i = 32'h000A_4903; in_valid_i = 1'b1; reg2_data_i = 32'h8000_0000; reg1_data_i = 32'h5555_5555;
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'h4 || ex_reg2_o !== 32'h8000_0000) begin err_cnt++; $display("FAIL sra_ops: got %h %h exp 00000004 80000000", ex_reg1_o, ex_reg2_o); end
        vec_cnt++; if (ex_wd_o !== 5'd9 || ex_aluop_o !== 8'h03 || ex_alusel_o !== 3'b010) begin err_cnt++; $display("FAIL sra_op: got %0d %h %b exp 9 03 010", ex_wd_o, ex_aluop_o, ex_alusel_o); end
        // LW $11,-4($1)
        @(negedge clk);
        idle_inputs();
        inst_i = 32'h8C2B_FFFC; in_valid_i = 1'b1; reg1_data_i = 32'h0000_0100;
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'h100 || ex_reg2_o !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL lw_ops: got %h %h exp 00000100 fffffffc", ex_reg1_o, ex_reg2_o); end
        vec_cnt++; if (ex_wd_o !== 5'd11 || ex_is_load_o !== 1'b1 || ex_aluop_o !== 8'hE3 || ex_alusel_o !== 3'b111) begin err_cnt++; $display("FAIL lw_op: got %0d %b %h %b exp 11 1 e3 111", ex_wd_o, ex_is_load_o, ex_aluop_o, ex_alusel_o); end
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        idle_inputs();
        inst_i = 32'h0022_1821; in_valid_i = 1'b1; reg1_data_i = 32'h0; reg2_data_i = 32'h22;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA_AAAA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h5555_5555;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b0) begin err_cnt++; $display("FAIL fwd_stall: got %b exp 0", stall_req_o); end
        vec_cnt++; if (nf_stall_req !== 1'b1) begin err_cnt++; $display("FAIL nofwd_stall: got %b exp 1", nf_stall_req); end
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'hAAAA_AAAA) begin err_cnt++; $display("FAIL fwd_ex_reg1: got %h exp aaaaaaaa", ex_reg1_o); end
        vec_cnt++; if (ex_reg2_o !== 32'h22 || ex_wd_o !== 5'd3 || ex_aluop_o !== 8'h21 || ex_alusel_o !== 3'b100) begin err_cnt++; $display("FAIL fwd_addu: got %h %0d %h %b exp 22 3 21 100", ex_reg2_o, ex_wd_o, ex_aluop_o, ex_alusel_o); end
        vec_cnt++; if (nf_valid !== 1'b0 || nf_wreg !== 1'b0) begin err_cnt++; $display("FAIL nofwd_bubble: got %b %b exp 0 0", nf_valid, nf_wreg); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs();
        inst_i = 32'h0080_2825; in_valid_i = 1'b1; reg1_data_i = 32'h99;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'hDEAD_0000; ex_is_load_i = 1'b1;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b1) begin err_cnt++; $display("FAIL lu_stall: got %b exp 1", stall_req_o); end
        @(posedge clk); #1;
        vec_cnt++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0 || ex_aluop_o !== 8'h00 || ex_reg1_o !== 32'h0) begin err_cnt++; $display("FAIL lu_bubble: got %b %b %h %h exp 0 0 00 0", ex_valid_o, ex_wreg_o, ex_aluop_o, ex_reg1_o); end
        @(negedge clk);
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 32'h0000_0042;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b0) begin err_cnt++; $display("FAIL lu_release: got %b exp 0", stall_req_o); end
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'h42 || ex_reg2_o !== 32'h0 || ex_valid_o !== 1'b1 || ex_wd_o !== 5'd5) begin err_cnt++; $display("FAIL lu_mem_fwd: got %h %h %b %0d exp 42 0 1 5", ex_reg1_o, ex_reg2_o, ex_valid_o, ex_wd_o); end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        idle_inputs();
        inst_i = 32'h0002_3821; in_valid_i = 1'b1; reg1_data_i = 32'h7777_7777; reg2_data_i = 32'h11;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'hFFFF_FFFF; ex_is_load_i = 1'b1;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd0; mem_wdata_i = 32'hFFFF_FFFF;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b0 || nf_stall_req !== 1'b0) begin err_cnt++; $display("FAIL r0_stall: got %b %b exp 0 0", stall_req_o, nf_stall_req); end
        @(posedge clk); #1;
        vec_cnt++; if (ex_reg1_o !== 32'h0 || ex_reg2_o !== 32'h11 || ex_valid_o !== 1'b1) begin err_cnt++; $display("FAIL r0_operand: got %h %h %b exp 0 11 1", ex_reg1_o, ex_reg2_o, ex_valid_o); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        idle_inputs();
        inst_i = 32'hFC00_0000; in_valid_i = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (ex_invalid_o !== 1'b1 || ex_wreg_o !== 1'b0 || ex_aluop_o !== 8'h00) begin err_cnt++; $display("FAIL illegal: got inv %b wreg %b aluop %h exp 1 0 00", ex_invalid_o, ex_wreg_o, ex_aluop_o); end
        @(negedge clk);
        inst_i = 32'h0000_003F;
        @(posedge clk); #1;
        vec_cnt++; if (ex_invalid_o !== 1'b1 || ex_wreg_o !== 1'b0) begin err_cnt++; $display("FAIL illegal_funct: got inv %b wreg %b exp 1 0", ex_invalid_o, ex_wreg_o); end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        idle_inputs();
        pc_i = 32'h0000_0200; inst_i = 32'h3422_00FF; in_valid_i = 1'b1; reg1_data_i = 32'h1234_0000;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall_i = 1'b1; pc_i = 32'h0000_0300 + 32'(i); inst_i = 32'h0022_1821; reg1_data_i = 32'h9;
            @(posedge clk); #1;
            vec_cnt++; if (ex_reg1_o !== 32'h1234_0000 || ex_pc_o !== 32'h200 || ex_wd_o !== 5'd2 || ex_valid_o !== 1'b1) begin err_cnt++; $display("FAIL stall_hold%0d: got %h %h %0d %b exp 12340000 200 2 1", i, ex_reg1_o, ex_pc_o, ex_wd_o, ex_valid_o); end
        end
        // load-use hazard while held: request still raised, register holds
        @(negedge clk);
        inst_i = 32'h0080_2825; ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_is_load_i = 1'b1;
        #1;
        vec_cnt++; if (stall_req_o !== 1'b1) begin err_cnt++; $display("FAIL stall_lu_req: got %b exp 1", stall_req_o); end
        @(posedge clk); #1;
        vec_cnt++; if (ex_valid_o !== 1'b1 || ex_reg1_o !== 32'h1234_0000) begin err_cnt++; $display("FAIL stall_lu_hold: got %b %h exp 1 12340000", ex_valid_o, ex_reg1_o); end
        @(negedge clk);
        flush_i = 1'b1; ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0 || ex_reg1_o !== 32'h0 || ex_pc_o !== 32'h0 || ex_aluop_o !== 8'h00) begin err_cnt++; $display("FAIL flush_bubble: got %b %b %h %h %h exp 0 0 0 0 00", ex_valid_o, ex_wreg_o, ex_reg1_o, ex_pc_o, ex_aluop_o); end
        @(negedge clk);
        idle_inputs();
        pc_i = 32'h0000_0400; inst_i = 32'h3422_00FF; in_valid_i = 1'b1; reg1_data_i = 32'h1;
        @(posedge clk); #1;
        vec_cnt++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h400) begin err_cnt++; $display("FAIL reload: got %b %h exp 1 400", ex_valid_o, ex_pc_o); end
        @(negedge clk);
        stall_i = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0 || ex_reg1_o !== 32'h0 || ex_reg2_o !== 32'h0 || ex_pc_o !== 32'h0 || ex_wd_o !== 5'd0) begin err_cnt++; $display("FAIL rst_in_stall: got %b %b %h %h %h %0d exp zeros", ex_valid_o, ex_wreg_o, ex_reg1_o, ex_reg2_o, ex_pc_o, ex_wd_o); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_ori();
        test_imm_forms();
        test_fwd_priority();
        test_load_use();
        test_reg0();
        test_illegal();
        test_stall_flush();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
